// File: rtl/act_feeder.sv
// act_feeder -- row feeder in front of the skew-delay stage.
//
// Buffers whole activation rows (N lanes of DATA_W bits) in a small FIFO and
// emits them one per cycle as a registered, unskewed row. After the last row
// of a tile, the feeder drains for N-1 zero cycles so the downstream skew
// stage can empty. The end of the drain is flagged with a one-cycle tile_done.
//
// Optional build feature: define ACT_FEEDER_STATS_EN to add the stall_cycles
// counter. It is a saturating count of STREAM cycles that had no row to send.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   in_valid     upstream row valid
//   in_ready     FIFO not full
//   in_data      input row, lane i goes to out_data[i]
//   in_last      row is the final row of a tile
//   out_data     registered row, zero when out_valid is low
//   out_valid    out_data carries a real row
//   busy         FSM is not IDLE
//   tile_done    one-cycle pulse when a tile's drain completes
//   stall_cycles (ACT_FEEDER_STATS_EN only) saturating bubble count
//
// state  | meaning
// IDLE   | waiting for the first row of a tile
// STREAM | popping one row per cycle, a bubble when the FIFO is empty
// FLUSH  | N-1 zero cycles after a last row, no pops
module act_feeder #(
  parameter int N          = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data [N-1:0],
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data [N-1:0],
  output logic              out_valid,
  output logic              busy,
  output logic              tile_done
`ifdef ACT_FEEDER_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH-1:0][N-1:0];
  logic              mem_last [FIFO_DEPTH-1:0];

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              last_pend;
  logic              full, empty, push, pop, head_last;

  // The extra top pointer bit tells a full FIFO from an empty one.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign pop       = !empty && (state != FLUSH);
  assign head_last = mem_last[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < N; i++) mem_data[wr_ptr[AW-1:0]][i] <= in_data[i];
      mem_last[wr_ptr[AW-1:0]] <= in_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      tile_done <= 1'b0;
      last_pend <= 1'b0;
      for (int i = 0; i < N; i++) out_data[i] <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      // With N == 1 there is no drain; the pulse trails the last row by one cycle.
      tile_done <= last_pend || ((state == FLUSH) && (cnt == CNT_ONE));
      last_pend <= 1'b0;

      case (state)
        IDLE, STREAM: begin
          if (pop) begin
            for (int i = 0; i < N; i++) out_data[i] <= mem_data[rd_ptr[AW-1:0]][i];
            out_valid <= 1'b1;
            if (head_last) begin
              if (N > 1) begin
                state <= FLUSH;
                cnt   <= CNT_W'(N - 1);
              end else begin
                state     <= IDLE;
                last_pend <= 1'b1;
              end
            end else begin
              state <= STREAM;
            end
          end else begin
            for (int i = 0; i < N; i++) out_data[i] <= '0;
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          for (int i = 0; i < N; i++) out_data[i] <= '0;
          out_valid <= 1'b0;
          cnt       <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          for (int i = 0; i < N; i++) out_data[i] <= '0;
        end
      endcase
    end
  end

`ifdef ACT_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if ((state == STREAM) && empty && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/act_feeder.md
ACT_FEEDER -- requirements
Module: act_feeder

Interface
REQ-001 Parameter N, default 8: lanes per row; equals the downstream skew-delay lane count; N >= 1.
REQ-002 Parameter DATA_W, default 32: bits per lane.
REQ-003 Parameter FIFO_DEPTH, default 4: row-buffer depth in rows; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream row valid.
REQ-007 in_ready  output  1  feeder can accept a row.
REQ-008 in_data  input  N x DATA_W (unpacked array [N-1:0])  row, lane i to out_data[i].
REQ-009 in_last  input  1  row is the final row of a tile.
REQ-010 out_data  output  N x DATA_W (unpacked array [N-1:0])  registered unskewed row to the skew-delay stage.
REQ-011 out_valid  output  1  out_data carries a real row this cycle.
REQ-012 busy  output  1  state is not IDLE.
REQ-013 tile_done  output  1  one-cycle pulse when a tile's drain completes.

Function
REQ-014 A row, with its in_last flag, SHALL be written to the FIFO on a rising edge with in_valid && in_ready.
REQ-015 in_ready SHALL equal FIFO not full, in every state; a push and a pop in the same cycle on a non-full FIFO SHALL both occur.
REQ-016 FSM states SHALL be IDLE, STREAM, FLUSH.
REQ-017 IDLE: with the FIFO non-empty, pop the head row into out_data, assert out_valid and enter STREAM; otherwise out_data = 0, out_valid = 0.
REQ-018 STREAM: each cycle with the FIFO non-empty, pop one row into out_data, out_valid = 1; with the FIFO empty, a bubble: out_data = 0, out_valid = 0.
REQ-019 When the popped row has in_last = 1 and N > 1, the next state SHALL be FLUSH with a drain counter loaded to N-1.
REQ-020 FLUSH: out_data = 0, out_valid = 0, no pops, counter decrements each cycle; at counter = 1, the next state SHALL be IDLE.
REQ-021 tile_done SHALL be 1 for exactly the first cycle in IDLE after FLUSH; with N == 1, it SHALL be 1 for the cycle after the last row is output, and the state SHALL return directly to IDLE.
REQ-022 Minimum latency: a row accepted at edge k into an empty FIFO in IDLE or STREAM SHALL appear on out_data after edge k+1.
REQ-023 Row order SHALL be preserved; no row SHALL be dropped or duplicated.
REQ-024 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished with an extra pointer bit.

Reset
REQ-025 While rst = 0, the block SHALL asynchronously force the following: state IDLE, FIFO empty, drain counter 0, out_data all 0, out_valid 0, busy 0, tile_done 0, in_ready 1.
REQ-026 A reset in any state, including mid-FLUSH, SHALL discard all buffered rows and SHALL NOT pulse tile_done.

Configuration
REQ-027 Macro ACT_FEEDER_STATS_EN defined: add output stall_cycles, 32 bits, reset 0; it SHALL increment by 1 for each STREAM bubble cycle, saturate at 0xFFFFFFFF, and clear only on reset.
REQ-028 Macro undefined: no stall_cycles port and no counter logic; all other behaviour SHALL be identical.

Verification (N=4, FIFO_DEPTH=4, DATA_W=32)
REQ-029 Case 1, reset: assert rst = 0 mid-STREAM. Required: out_data = {0,0,0,0}, out_valid = 0, busy = 0, in_ready = 1 immediately, without waiting for a clock edge.
REQ-030 Case 2, single-row tile: row {1,2,3,4} with in_last accepted at edge 1. Required: out_data = {1,2,3,4} and out_valid = 1 after edge 2; zeros with out_valid = 0 after edges 3-5; tile_done = 1 only after edge 5; busy = 0 from edge 5.
REQ-031 Case 3, backpressure: 5 rows offered back-to-back during FLUSH. Required: in_ready = 0 after the 4th accept; the 5th row is held stable and accepted after the first pop; output order is 1..5.
REQ-032 Case 4, bubbles: in STREAM, rows 10 and 20 arrive 3 cycles apart. Required: out_valid pattern 1,0,0,1; out_data = 0 in the bubbles; with the macro, stall_cycles = 2.
REQ-033 Case 5, reset mid-FLUSH: assert rst after 1 drain cycle. Required: state IDLE; tile_done never pulses; a new row after rst release appears after 2 edges.
REQ-034 Case 6, simultaneous push/pop: FIFO holding 2 rows, one push and one pop per cycle for 8 cycles. Required: occupancy stays at 2, in_ready = 1 throughout, data in order.
